// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 digest read-out path.
package sha256_pkg;

  localparam int DIGEST_W = 256;
  localparam int WORD_W   = 64;
  localparam int NWORDS   = DIGEST_W / WORD_W;
  localparam int CNT_W    = $clog2(NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } reader_state_t;

endpackage

// File: rtl/sha256_digest_reader.sv
// Captures the final SHA-256 digest and streams it out MSW-first as 64-bit
// words over a valid/ready handshake.
module sha256_digest_reader
  import sha256_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                digest_valid_i,
  input  logic [DIGEST_W-1:0] digest_i,
  output logic                accept_o,
  output logic [WORD_W-1:0]   data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic [CNT_W-1:0]    word_idx_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  reader_state_t       state_r, state_s;
  logic [DIGEST_W-1:0] shreg_r, shreg_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                done_r, done_s;
  logic                overrun_r, overrun_s;

  // Next-state, shift and pulse generation for the read-out FSM
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    cnt_s     = cnt_r;
    done_s    = 1'b0;
    overrun_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (digest_valid_i) begin
          shreg_s = digest_i;
          cnt_s   = {CNT_W{1'b0}};
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // A digest arriving mid-stream is dropped and only flagged
        if (digest_valid_i) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = 1'b0;
        end
        if (ready_i) begin
          shreg_s = {shreg_r[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
          if (cnt_r == LAST_IDX) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
            done_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = {DIGEST_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, shift register, counter and pulse registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      shreg_r   <= {DIGEST_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      cnt_r     <= cnt_s;
      done_r    <= done_s;
      overrun_r <= overrun_s;
    end
  end

  // The shift register is all-zero whenever idle, so data_o needs no gating
  assign valid_o    = (state_r == SEND);
  assign accept_o   = RST & (state_r == IDLE);
  assign data_o     = shreg_r[DIGEST_W-1 -: WORD_W];
  assign word_idx_o = cnt_r;
  assign last_o     = valid_o & (cnt_r == LAST_IDX);
  assign done_o     = done_r;
  assign overrun_o  = overrun_r;

endmodule
